// File: rtl/sreg_load_ctrl_18_if.sv
// Handshake bundle for the serial-to-parallel word sequencer.
// master drives the request/serial/accept side, slave is the sequencer.
interface sreg_load_ctrl_18_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             start;
  logic             sin;
  logic             q_ready;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output start,
    output sin,
    output q_ready,
    input  q,
    input  q_valid,
    input  busy,
    input  bit_cnt
  );

  modport slave (
    input  start,
    input  sin,
    input  q_ready,
    output q,
    output q_valid,
    output busy,
    output bit_cnt
  );
endinterface

// File: rtl/sreg_load_ctrl_18.sv
// Serial-in/parallel-out sequencer: counts WIDTH bits into a chain,
// then hands the word to a holding register under valid/ready.
module sreg_load_ctrl_18 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input logic ck,
  input logic rst_n,
  sreg_load_ctrl_18_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] chain;
  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic             busy_r;
  logic [CNT_W-1:0] cnt;
  logic             free;

  assign free = !q_valid_r || bus.q_ready;

  // All state moves on the falling edge of ck.
  always_ff @(negedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      chain     <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      cnt       <= '0;
    end else begin
      // consume; a load in DONE below overrides this
      if (q_valid_r && bus.q_ready)
        q_valid_r <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= SHIFT;
            cnt    <= '0;
            busy_r <= 1'b1;
          end
        end

        SHIFT: begin
          chain <= {chain[WIDTH-2:0], bus.sin};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST)
            state <= DONE;
        end

        DONE: begin
          if (free) begin
            q_r       <= chain;
            q_valid_r <= 1'b1;
            cnt       <= '0;
            if (bus.start) begin
              state  <= SHIFT;
              busy_r <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.busy    = busy_r;
  assign bus.bit_cnt = cnt;

endmodule

// File: tb/tb_sreg_load_ctrl_18.sv
// Scoreboard bench for sreg_load_ctrl_18: words queued on issue,
// popped and compared whenever the consumer takes q.
module tb_sreg_load_ctrl_18;

  localparam int W  = 4;
  localparam int CW = 3;

  logic ck    = 1'b1;
  logic rst_n = 1'b1;

  sreg_load_ctrl_18_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  sreg_load_ctrl_18 #(.WIDTH(W), .CNT_W(CW)) dut (
    .ck   (ck),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 ck = ~ck;

  int errs   = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  // Inputs change just after a falling edge, so at the rising edge
  // q_valid/q_ready are exactly what the next falling edge will see.
  always @(posedge ck) begin
    if (rst_n && bus.q_valid === 1'b1 && bus.q_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL scoreboard: got q=%b but no word expected", bus.q);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.q !== mon_e) begin
          errs++;
          $display("FAIL scoreboard: got q=%b expected %b", bus.q, mon_e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge ck);
    #1;
  endtask

  task automatic begin_word();
    bus.start = 1'b1;
    tick();
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_cnt", 32'(bus.bit_cnt), 0);
    bus.start = 1'b0;
  endtask

  task automatic shift_bits(input logic [3:0] b, input logic pulse2);
    for (int i = 0; i < 4; i++) begin
      bus.sin = b[3-i];
      if (pulse2) bus.start = (i == 1);
      tick();
      chk("bit_cnt", 32'(bus.bit_cnt), 32'(i + 1));
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.sin     = 1'b0;
    bus.q_ready = 1'b0;

    // asynchronous reset between edges
    #12 rst_n = 1'b0;
    #1;
    chk("rst_q", 32'(bus.q), 0);
    chk("rst_q_valid", 32'(bus.q_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_bit_cnt", 32'(bus.bit_cnt), 0);
    #4 rst_n = 1'b1;
    tick();

    // basic word 1011
    bus.q_ready = 1'b1;
    begin_word();
    shift_bits(4'b1011, 1'b0);
    chk("basic_busy_done", 32'(bus.busy), 1);
    chk("basic_nvalid", 32'(bus.q_valid), 0);
    exp_q.push_back(4'b1011);
    tick();
    chk("basic_q", 32'(bus.q), 32'hB);
    chk("basic_valid", 32'(bus.q_valid), 1);
    chk("basic_idle", 32'(bus.busy), 0);
    chk("basic_cnt0", 32'(bus.bit_cnt), 0);
    tick();
    chk("basic_consumed", 32'(bus.q_valid), 0);

    // stall: A held unconsumed while 0110 arrives
    bus.q_ready = 1'b0;
    begin_word();
    shift_bits(4'b1010, 1'b0);
    exp_q.push_back(4'hA);
    tick();
    chk("stall_qa", 32'(bus.q), 32'hA);
    begin_word();
    shift_bits(4'b0110, 1'b0);
    exp_q.push_back(4'b0110);
    tick();
    tick();
    chk("stall_busy", 32'(bus.busy), 1);
    chk("stall_q_hold", 32'(bus.q), 32'hA);
    chk("stall_cnt", 32'(bus.bit_cnt), 4);
    chk("stall_valid", 32'(bus.q_valid), 1);
    bus.q_ready = 1'b1;
    tick();
    chk("stall_q_new", 32'(bus.q), 32'h6);
    chk("stall_valid_kept", 32'(bus.q_valid), 1);
    chk("stall_released", 32'(bus.busy), 0);
    tick();
    chk("stall_drained", 32'(bus.q_valid), 0);

    // back-to-back with start held
    bus.start = 1'b1;
    tick();
    shift_bits(4'b1100, 1'b0);
    exp_q.push_back(4'b1100);
    tick();
    chk("b2b_q1", 32'(bus.q), 32'hC);
    chk("b2b_valid1", 32'(bus.q_valid), 1);
    chk("b2b_busy", 32'(bus.busy), 1);
    chk("b2b_cnt0", 32'(bus.bit_cnt), 0);
    shift_bits(4'b0011, 1'b0);
    bus.start = 1'b0;
    exp_q.push_back(4'b0011);
    tick();
    chk("b2b_q2", 32'(bus.q), 32'h3);
    chk("b2b_idle", 32'(bus.busy), 0);

    // start pulse during SHIFT is ignored
    begin_word();
    shift_bits(4'b0111, 1'b1);
    exp_q.push_back(4'b0111);
    tick();
    chk("ign_q", 32'(bus.q), 32'h7);
    chk("ign_idle", 32'(bus.busy), 0);

    // reset after two bits discards the partial word
    begin_word();
    bus.sin = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_cnt", 32'(bus.bit_cnt), 0);
    chk("mrst_valid", 32'(bus.q_valid), 0);
    chk("mrst_q", 32'(bus.q), 0);
    rst_n = 1'b1;
    tick();
    begin_word();
    shift_bits(4'b0101, 1'b0);
    exp_q.push_back(4'b0101);
    tick();
    chk("mrst_q_new", 32'(bus.q), 32'h5);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
